// File: rtl/audio_pcm_dac.sv
// audio_pcm_dac: FIFO-buffered stereo PCM stream to two first-order sigma-delta bitstreams
// Ports: clk/rst_n (sync, active-low); in_data/in_valid/in_ready sample stream ([31:16] L, [15:0] R);
// audio[1]=L, audio[0]=R bitstreams; sample_tick once per SAMPLE_DIV cycles; fifo_level words held;
// underflow_cnt saturating count of ticks that found the FIFO empty.
module audio_pcm_dac #(
  parameter int SAMPLE_DIV = 500,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [1:0]         audio,
  output logic               sample_tick,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [7:0]         underflow_cnt
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  logic [DW-1:0] div_cnt;
  logic [31:0] mem [DEPTH];
  logic [FIFO_AW:0] wp, rp;
  logic [15:0] cur_l, cur_r, acc_l, acc_r;
  logic [16:0] sum_l, sum_r;
  logic push, pop, empty;
  assign fifo_level = wp - rp;
  assign empty = wp == rp;
  assign in_ready = fifo_level != (FIFO_AW+1)'(DEPTH);
  assign sample_tick = div_cnt == DW'(SAMPLE_DIV - 1);
  assign push = in_valid & in_ready;
  assign pop = sample_tick & ~empty;
  // offset binary: flipping the sign bit maps signed full scale onto 0..65535 ones density
  assign sum_l = {1'b0, acc_l} + {1'b0, cur_l ^ 16'h8000};
  assign sum_r = {1'b0, acc_r} + {1'b0, cur_r ^ 16'h8000};
  always_ff @(posedge clk)
    if (rst_n && push) mem[wp[FIFO_AW-1:0]] <= in_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      wp <= '0;
      rp <= '0;
      cur_l <= '0;
      cur_r <= '0;
      acc_l <= '0;
      acc_r <= '0;
      audio <= 2'b00;
      underflow_cnt <= '0;
    end else begin
      div_cnt <= sample_tick ? '0 : div_cnt + 1'b1;
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        {cur_l, cur_r} <= mem[rp[FIFO_AW-1:0]];
        rp <= rp + 1'b1;
      end
      // emptiness is judged before any same-cycle push, so push+tick on empty is an underflow
      if (sample_tick && empty && underflow_cnt != 8'hFF) underflow_cnt <= underflow_cnt + 1'b1;
      acc_l <= sum_l[15:0];
      acc_r <= sum_r[15:0];
      audio <= {sum_l[16], sum_r[16]};
    end
  end
endmodule

// File: tb/tb_audio_pcm_dac.sv
// tb_audio_pcm_dac: randomized and directed checks of audio_pcm_dac against a queue-based model
module tb_audio_pcm_dac;
  logic clk = 0, rst_n = 0, in_valid = 0;
  logic [31:0] in_data = 0;
  logic in_ready, sample_tick;
  logic [1:0] audio;
  logic [2:0] fifo_level;
  logic [7:0] underflow_cnt;
  int n_assert = 0, n_fail = 0;

  audio_pcm_dac #(.SAMPLE_DIV(8), .FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .audio(audio), .sample_tick(sample_tick), .fifo_level(fifo_level), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] q[$];
  bit armed = 0, m_tick, m_push;
  int cyc = 0, acc_l = 0, acc_r = 0, m_uf = 0, sl, sr;
  logic [15:0] m_l = 0, m_r = 0;
  logic [1:0] m_audio = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      armed = 1;
      q.delete();
      cyc = 0;
      m_l = 0;
      m_r = 0;
      acc_l = 0;
      acc_r = 0;
      m_audio = 0;
      m_uf = 0;
    end else begin
      m_tick = cyc % 8 == 7;
      m_push = in_valid && q.size() < 4;
      sl = acc_l + int'(m_l ^ 16'h8000);
      sr = acc_r + int'(m_r ^ 16'h8000);
      m_audio = {sl >= 65536, sr >= 65536};
      acc_l = sl % 65536;
      acc_r = sr % 65536;
      if (m_tick) begin
        if (q.size() > 0) {m_l, m_r} = q.pop_front();
        else if (m_uf < 255) m_uf++;
      end
      if (m_push) q.push_back(in_data);
      cyc++;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk)
    if (armed) begin
      chk("audio", audio, m_audio);
      chk("in_ready", in_ready, q.size() != 4);
      chk("fifo_level", fifo_level, q.size());
      chk("underflow_cnt", underflow_cnt, m_uf);
      chk("sample_tick", sample_tick, cyc % 8 == 7);
    end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    in_valid = 0;
    repeat (2) step();
    rst_n = 1;
  endtask

  task automatic to_tick();
    for (int i = 0; i < 16 && cyc % 8 != 7; i++) step();
  endtask

  task automatic window(input int n, output int ol, output int orr, output int tl);
    logic prev;
    ol = 0;
    orr = 0;
    tl = 0;
    prev = audio[1];
    for (int i = 0; i < n; i++) begin
      ol += int'(audio[1]);
      orr += int'(audio[0]);
      if (i > 0 && audio[1] != prev) tl++;
      prev = audio[1];
      step();
    end
  endtask

  initial begin
    int first, second, ol, orr, tl;
    logic [31:0] w;
    repeat (3) step();
    chk("rst_audio", audio, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_uf", underflow_cnt, 0);
    rst_n = 1;
    first = -1;
    second = -1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (sample_tick) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    chk("first_tick", first, 7);
    chk("second_tick", second, 15);
    in_valid = 1;
    in_data = 32'h0;
    step();
    in_valid = 0;
    to_tick();
    repeat (2) step();
    window(8, ol, orr, tl);
    chk("zero_l_ones", ol, 4);
    chk("zero_r_ones", orr, 4);
    chk("zero_l_toggles", tl, 7);
    do_reset();
    in_valid = 1;
    in_data = 32'h7FFF_8000;
    to_tick();
    repeat (2) step();
    window(65536, ol, orr, tl);
    chk("fs_l_ones", ol, 65535);
    chk("fs_r_ones", orr, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w = 32'h0001_0001 * (i + 1);
      in_valid = 1;
      in_data = w;
      step();
    end
    in_data = 32'h0005_0005;
    chk("full_level", fifo_level, 4);
    chk("full_ready", in_ready, 0);
    repeat (4) step();
    chk("after_tick_ready", in_ready, 1);
    chk("after_tick_level", fifo_level, 3);
    step();
    chk("fifth_accepted", fifo_level, 4);
    in_valid = 0;
    repeat (48) step();
    do_reset();
    in_valid = 1;
    in_data = 32'h4000_C000;
    step();
    in_valid = 0;
    repeat (31) step();
    chk("uf_three", underflow_cnt, 3);
    window(8, ol, orr, tl);
    chk("uf_l_ones", ol, 6);
    chk("uf_r_ones", orr, 2);
    repeat (2400) step();
    chk("uf_sat", underflow_cnt, 255);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_data = $urandom;
      step();
    end
    chk("mid_level3", fifo_level, 3);
    in_data = $urandom;
    rst_n = 0;
    step();
    chk("mid_rst_level", fifo_level, 0);
    step();
    in_valid = 0;
    rst_n = 1;
    repeat (7) step();
    in_valid = 1;
    in_data = $urandom;
    step();
    in_valid = 0;
    chk("pt_uf", underflow_cnt, 1);
    chk("pt_level", fifo_level, 1);
    repeat (8) step();
    chk("pt_popped", fifo_level, 0);
    chk("pt_uf_hold", underflow_cnt, 1);
    repeat (16) step();
    for (int i = 0; i < 4000; i++) begin
      if (!(in_valid && q.size() == 4)) begin
        in_valid = $urandom_range(0, 99) < (i < 2000 ? 20 : 6);
        in_data = $urandom;
      end
      rst_n = $urandom_range(0, 499) != 0;
      step();
    end
    in_valid = 0;
    rst_n = 1;
    repeat (10) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
